// File: rtl/spi_adc_sampler.sv
// SPI master for a serial ADC: single-shot or timer-paced frames, sample extraction, overrun flag.
// Build option ADC_SIGNED_EN: invert the sample MSB (offset-binary -> two's complement).
module spi_adc_sampler #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int LSB_PAD    = 0,
    parameter int SCK_DIV    = 4,
    parameter int QUIET_CYC  = 8,
    parameter int SAMPLE_DIV = 2268
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miso,
    input  logic                 start,
    input  logic                 auto_en,
    output logic                 cs_n,
    output logic                 sck_out,
    output logic                 busy,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 overrun
);

    localparam int CNT_MAX = (SCK_DIV > QUIET_CYC) ? SCK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS);
    localparam int TMR_W   = $clog2(SAMPLE_DIV);
    localparam int SH_W    = LSB_PAD + DATA_BITS;

    localparam logic [CNT_W-1:0] SCK_LAST   = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic                 phase_hi, phase_hi_nx;
    // Only the sample and pad bits are kept; leading frame bits fall off the top.
    logic [SH_W-1:0]      shift_reg, shift_nx;
    logic [TMR_W-1:0]     timer;
    logic                 tick;
    logic                 trigger;
    logic [DATA_BITS-1:0] sample, sample_fmt;
    logic                 cs_n_nx, sck_nx, busy_nx, ready_nx, overrun_nx;
    logic [DATA_BITS-1:0] data_nx;

    // Sample-rate timer; tick is registered so it arrives SAMPLE_DIV cycles after auto_en rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= auto_en && (timer == TMR_LAST);
            if (!auto_en || timer == TMR_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign sample = shift_reg[SH_W-1:LSB_PAD];

`ifdef ADC_SIGNED_EN
    localparam logic [DATA_BITS-1:0] SIGN_MASK = DATA_BITS'(1) << (DATA_BITS - 1);
    assign sample_fmt = sample ^ SIGN_MASK;
`else
    assign sample_fmt = sample;
`endif

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        bit_cnt_nx  = bit_cnt;
        phase_hi_nx = phase_hi;
        shift_nx    = shift_reg;
        trigger     = start | tick;

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx = SETUP;
                    cnt_nx   = '0;
                end
            end
            SETUP: begin
                if (cnt == SCK_LAST) begin
                    state_nx    = SHIFT;
                    cnt_nx      = '0;
                    phase_hi_nx = 1'b0;
                    bit_cnt_nx  = BIT_FIRST;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == SCK_LAST) begin
                    cnt_nx = '0;
                    if (!phase_hi) begin
                        // This edge raises sck, so it is also the miso capture edge.
                        phase_hi_nx = 1'b1;
                        shift_nx    = {shift_reg[SH_W-2:0], miso};
                    end else if (bit_cnt == '0) begin
                        state_nx = DONE;
                    end else begin
                        phase_hi_nx = 1'b0;
                        bit_cnt_nx  = bit_cnt - 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = QUIET;
                cnt_nx   = '0;
            end
            QUIET: begin
                if (cnt == QUIET_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are derived from the next state so they register in step with it.
        cs_n_nx    = !(state_nx == SETUP || state_nx == SHIFT);
        sck_nx     = !(state_nx == SHIFT && !phase_hi_nx);
        busy_nx    = (state_nx != IDLE);
        ready_nx   = (state_nx == DONE);
        overrun_nx = tick && (state != IDLE);
        data_nx    = (state_nx == DONE) ? sample_fmt : data_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            phase_hi  <= 1'b0;
            shift_reg <= '0;
            cs_n      <= 1'b1;
            sck_out   <= 1'b1;
            busy      <= 1'b0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            phase_hi  <= phase_hi_nx;
            shift_reg <= shift_nx;
            cs_n      <= cs_n_nx;
            sck_out   <= sck_nx;
            busy      <= busy_nx;
            ready     <= ready_nx;
            overrun   <= overrun_nx;
            data_out  <= data_nx;
        end
    end

endmodule
